// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states and bus-level constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        IGNORE
    } i2c_state_t;

    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and derives single-clk bus events:
// SCL rise/fall, START (SDA falls, SCL high) and STOP (SDA rises, SCL high).
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;

    // Two-flop synchronizers plus one delayed copy for edge detection; idle bus is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign sda       = sda_sync[1];
    assign scl_rise  =  scl_sync[1] & ~scl_prev;
    assign scl_fall  = ~scl_sync[1] &  scl_prev;
    // SCL must be high both before and after the SDA edge to count as a bus condition.
    assign start_det =  scl_sync[1] &  scl_prev &  sda_prev & ~sda_sync[1];
    assign stop_det  =  scl_sync[1] &  scl_prev & ~sda_prev &  sda_sync[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, register pointer, write stream and read stream
// against an external register file. SDA is open-drain (drive 0 or release).
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h68,
    parameter logic [7:0] PTR_RESET     = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL_BUS,
    inout  wire        SDA_BUS,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    input  logic [7:0] reg_rdata,
    output logic       reg_rd,
    output logic       busy
);

    i2c_state_t state;
    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       sda_oe;
    logic [3:0] bit_cnt;
    logic [6:0] shift;
    logic [6:0] tx;
    logic       rw;
    logic [7:0] next_byte;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (SCL_BUS),
        .sda_in    (SDA_BUS),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Byte as it will look once the bit on the current SCL rise is shifted in.
    assign next_byte = {shift, sda};

    // Open-drain: only ever pull low, otherwise let the pull-up win.
    assign SDA_BUS = sda_oe ? 1'b0 : 1'bz;

    // Protocol FSM; START/STOP override every state, SDA only changes on SCL fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            bit_cnt   <= 4'd0;
            shift     <= 7'd0;
            tx        <= 7'd0;
            rw        <= I2C_RW_WRITE;
            reg_addr  <= PTR_RESET;
            reg_wdata <= 8'd0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= next_byte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (next_byte[7:1] == SLAVE_ADDRESS) begin
                                    state <= ADDR_ACK;
                                    busy  <= 1'b1;
                                    rw    <= next_byte[0];
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end

                    // sda_oe doubles as phase: first fall drives ACK, second fall ends the 9th clock.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= ACK == 1'b0;
                            end else if (rw == I2C_RW_READ) begin
                                tx      <= reg_rdata[6:0];
                                sda_oe  <= ~reg_rdata[7];
                                reg_rd  <= 1'b1;
                                bit_cnt <= 4'd1;
                                state   <= RDATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= PTR;
                            end
                        end
                    end

                    PTR: begin
                        if (scl_rise) begin
                            shift   <= next_byte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                reg_addr <= next_byte;
                                state    <= PTR_ACK;
                            end
                        end
                    end

                    PTR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= WDATA;
                            end
                        end
                    end

                    WDATA: begin
                        if (scl_rise) begin
                            shift   <= next_byte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                reg_wdata <= next_byte;
                                reg_wr    <= 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end
                    end

                    // Pointer advances the clk after the write strobe so the strobe sees the old address.
                    WDATA_ACK: begin
                        if (reg_wr) begin
                            reg_addr <= reg_addr + 8'd1;
                        end
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= WDATA;
                            end
                        end
                    end

                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe   <= 1'b0;
                                reg_addr <= reg_addr + 8'd1;
                                state    <= RACK;
                            end else begin
                                sda_oe  <= ~tx[6];
                                tx      <= {tx[5:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // Entered on a fall, so the next edge is the master's ACK/NACK rise.
                    RACK: begin
                        if (scl_rise) begin
                            if (sda == NACK) begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall) begin
                            tx      <= reg_rdata[6:0];
                            sda_oe  <= ~reg_rdata[7];
                            reg_rd  <= 1'b1;
                            bit_cnt <= 4'd1;
                            state   <= RDATA;
                        end
                    end

                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
